fft_in_loader: RTL

Streaming front-end for the 256-point, 4-lane FFT core. It accepts one 64-bit complex sample per cycle on a valid/ready stream and packs four consecutive samples into one 4-lane word. Each word is driven, with its buffer address, onto the core's external data inputs D0..D3, and the loader pulses START for the core. It sits directly upstream of the core. It enforces frame length, zero-pads short frames, and holds off the stream until the core reports DONE.

---
 rtl/fft_in_loader.sv | 111 +++++++++++
 1 files changed

// File: rtl/fft_in_loader.sv
// Streaming front-end for the 4-lane FFT core: packs four samples per word,
// pads short frames with zeros and holds the stream off until the core is DONE.
module fft_in_loader #(
  parameter int WIDTH = 64,
  parameter int NPTS  = 256
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       S_VALID,
  output logic                       S_READY,
  input  logic [WIDTH-1:0]           S_DATA,
  input  logic                       S_LAST,
  output logic [WIDTH-1:0]           D0,
  output logic [WIDTH-1:0]           D1,
  output logic [WIDTH-1:0]           D2,
  output logic [WIDTH-1:0]           D3,
  output logic [$clog2(NPTS)-3:0]    WADDR,
  output logic                       W_VALID,
  output logic                       START,
  input  logic                       DONE,
  output logic                       LEN_ERR
);

  localparam int CW = $clog2(NPTS);
  localparam logic [CW-1:0] LAST_IDX = CW'(NPTS - 1);

  typedef enum logic [1:0] {ST_LOAD, ST_PAD, ST_WAIT} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    scnt_reg;
  logic [CW-3:0]    waddr_reg;
  logic             w_valid_reg, start_reg, len_err_reg;

  logic             accept, wr_en, emit, at_end, len_err;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] word_in [4];
  logic [WIDTH-1:0] d_lane  [4];

  always_comb begin
    S_READY    = (state_reg == ST_LOAD) && !RST;
    accept     = S_VALID && S_READY;
    wr_en      = accept || (state_reg == ST_PAD);
    wr_data    = (state_reg == ST_PAD) ? '0 : S_DATA;
    at_end     = (scnt_reg == LAST_IDX);
    emit       = wr_en && (scnt_reg[1:0] == 2'd3);
    // Error when LAST disagrees with the frame boundary, in either direction.
    len_err    = accept && (S_LAST != at_end);
    state_next = state_reg;
    case (state_reg)
      ST_LOAD: if (accept) begin
        if (at_end)      state_next = ST_WAIT;
        else if (S_LAST) state_next = ST_PAD;
      end
      ST_PAD:  if (at_end) state_next = ST_WAIT;
      ST_WAIT: if (DONE)   state_next = ST_LOAD;
      default:             state_next = ST_LOAD;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= ST_LOAD;
      scnt_reg    <= '0;
      waddr_reg   <= '0;
      w_valid_reg <= 1'b0;
      start_reg   <= 1'b0;
      len_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      // Counter wraps to zero after the last point, so WAIT starts at SCNT=0.
      if (wr_en) scnt_reg <= scnt_reg + 1'b1;
      if (emit)  waddr_reg <= scnt_reg[CW-1:2];
      w_valid_reg <= emit;
      start_reg   <= emit && (scnt_reg[CW-1:2] == '0);
      len_err_reg <= len_err;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [WIDTH-1:0] d_reg;
      if (gi < 3) begin : g_pack
        logic [WIDTH-1:0] pack_reg;
        always_ff @(posedge CLK) begin
          if (RST)                                     pack_reg <= '0;
          else if (wr_en && scnt_reg[1:0] == 2'(gi))   pack_reg <= wr_data;
        end
        assign word_in[gi] = pack_reg;
      end else begin : g_direct
        // The last lane completes the word, so it bypasses the pack register.
        assign word_in[gi] = wr_data;
      end
      always_ff @(posedge CLK) begin
        if (RST)       d_reg <= '0;
        else if (emit) d_reg <= word_in[gi];
      end
      assign d_lane[gi] = d_reg;
    end
  endgenerate

  assign D0      = d_lane[0];
  assign D1      = d_lane[1];
  assign D2      = d_lane[2];
  assign D3      = d_lane[3];
  assign WADDR   = waddr_reg;
  assign W_VALID = w_valid_reg;
  assign START   = start_reg;
  assign LEN_ERR = len_err_reg;

endmodule
